// File: rtl/vrf_banked_mp.sv
// Banked vector register file: one write port and two read ports served in
// parallel from single-port RAM banks, with conflict arbitration and a read
// starvation guard against a continuously granted writer.

// Single-port RAM with per-bit write mask and registered read data.
module prim_generic_ram_1p #(
    parameter  int unsigned Width = 32,
    parameter  int unsigned Depth = 8,
    localparam int unsigned Aw    = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic             clk_i,
    input  logic             req_i,
    input  logic             write_i,
    input  logic [Aw-1:0]    addr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic [Width-1:0] wmask_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [Depth];

    // One access per cycle: masked write or registered read.
    always_ff @(posedge clk_i) begin
        if (req_i) begin
            if (write_i) begin
                mem_q[addr_i] <= (mem_q[addr_i] & ~wmask_i) | (wdata_i & wmask_i);
            end else begin
                rdata_o <= mem_q[addr_i];
            end
        end
    end

endmodule

module vrf_banked_mp #(
    parameter int unsigned DataWidth  = 128,
    parameter int unsigned AddrWidth  = 5,
    parameter int unsigned NumBanks   = 4,
    parameter int unsigned MaxWrStall = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     wr_req_i,
    output logic                     wr_gnt_o,
    input  logic [AddrWidth-1:0]     wr_addr_i,
    input  logic [DataWidth-1:0]     wr_data_i,
    input  logic [DataWidth/8-1:0]   wr_be_i,
    input  logic [1:0]               rd_req_i,
    output logic [1:0]               rd_gnt_o,
    input  logic [2*AddrWidth-1:0]   rd_addr_i,
    output logic [1:0]               rd_rvalid_o,
    output logic [2*DataWidth-1:0]   rd_rdata_o
);

    localparam int unsigned LogBanks = (NumBanks > 1) ? $clog2(NumBanks) : 0;
    localparam int unsigned BankW    = (LogBanks > 0) ? LogBanks : 1;
    localparam int unsigned RowBits  = AddrWidth - LogBanks;
    localparam int unsigned RowW     = (RowBits > 0) ? RowBits : 1;
    localparam int unsigned Depth    = (2 ** AddrWidth) / NumBanks;
    localparam int unsigned CntW     = $clog2(MaxWrStall + 1);
    localparam int unsigned BeW      = DataWidth / 8;

    function automatic logic [BankW-1:0] bank_of(input logic [AddrWidth-1:0] a);
        return BankW'(a & AddrWidth'(NumBanks - 1));
    endfunction

    function automatic logic [RowW-1:0] row_of(input logic [AddrWidth-1:0] a);
        return RowW'(a >> LogBanks);
    endfunction

    logic [BankW-1:0]           wr_bank;
    logic [RowW-1:0]            wr_row;
    logic [1:0][BankW-1:0]      rd_bank;
    logic [1:0][RowW-1:0]       rd_row;
    logic [DataWidth-1:0]       wmask;

    logic                       rr_q, rr_d;
    logic [1:0][CntW-1:0]       stall_q, stall_d;
    logic [1:0]                 rvalid_q;
    logic [1:0][BankW-1:0]      rbank_q;
    logic [1:0][DataWidth-1:0]  hold_q, rdata_c;

    logic [1:0]                 starve;
    logic [1:0]                 wr_hit;
    logic                       rd_same_bank;
    logic                       rd0_first;
    logic                       wr_gnt;
    logic [1:0]                 rd_gnt;

    logic [DataWidth-1:0]       bank_rdata [NumBanks];

    // Address decode into bank/row and byte-enable expansion to a bit mask.
    always_comb begin
        wr_bank = bank_of(wr_addr_i);
        wr_row  = row_of(wr_addr_i);
        for (int p = 0; p < 2; p++) begin
            rd_bank[p] = bank_of(rd_addr_i[p*AddrWidth +: AddrWidth]);
            rd_row[p]  = row_of(rd_addr_i[p*AddrWidth +: AddrWidth]);
        end
        wmask = '0;
        for (int i = 0; i < BeW; i++) begin
            wmask[i*8 +: 8] = {8{wr_be_i[i]}};
        end
    end

    // Per-bank priority: starving reads, then the write, then reads in rr order.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            starve[p] = (stall_q[p] == CntW'(MaxWrStall));
            wr_hit[p] = wr_req_i && (wr_bank == rd_bank[p]);
        end
        rd_same_bank = rd_req_i[0] && rd_req_i[1] && (rd_bank[0] == rd_bank[1]);
        if (starve[0] != starve[1]) begin
            rd0_first = starve[0];
        end else begin
            rd0_first = ~rr_q;
        end
        wr_gnt = wr_req_i
                 && !(rd_req_i[0] && starve[0] && wr_hit[0])
                 && !(rd_req_i[1] && starve[1] && wr_hit[1]);
        rd_gnt[0] = rd_req_i[0] && !(wr_hit[0] && !starve[0])
                    && !(rd_same_bank && !rd0_first);
        rd_gnt[1] = rd_req_i[1] && !(wr_hit[1] && !starve[1])
                    && !(rd_same_bank && rd0_first);
    end

    assign wr_gnt_o = wr_gnt;
    assign rd_gnt_o = rd_gnt;

    // Round-robin toggle on granted read-read conflicts; stall counters track write-caused stalls.
    always_comb begin
        rr_d = rr_q;
        if (rd_same_bank && (rd_gnt[0] || rd_gnt[1])) begin
            rr_d = ~rr_q;
        end
        for (int p = 0; p < 2; p++) begin
            stall_d[p] = stall_q[p];
            if (!rd_req_i[p] || rd_gnt[p]) begin
                stall_d[p] = '0;
            end else if (wr_gnt && (wr_bank == rd_bank[p])
                         && (stall_q[p] != CntW'(MaxWrStall))) begin
                stall_d[p] = stall_q[p] + CntW'(1);
            end
        end
    end

    // Bank instances; arbitration guarantees at most one granted access per bank.
    for (genvar b = 0; b < NumBanks; b++) begin : g_bank
        logic            sel_w, sel_r0, sel_r1;
        logic [RowW-1:0] addr;

        assign sel_w  = wr_gnt    && (wr_bank    == BankW'(b));
        assign sel_r0 = rd_gnt[0] && (rd_bank[0] == BankW'(b));
        assign sel_r1 = rd_gnt[1] && (rd_bank[1] == BankW'(b));
        assign addr   = sel_w ? wr_row : (sel_r0 ? rd_row[0] : rd_row[1]);

        prim_generic_ram_1p #(
            .Width (DataWidth),
            .Depth (Depth)
        ) u_ram (
            .clk_i   (clk_i),
            .req_i   (sel_w || sel_r0 || sel_r1),
            .write_i (sel_w),
            .addr_i  (addr),
            .wdata_i (wr_data_i),
            .wmask_i (wmask),
            .rdata_o (bank_rdata[b])
        );
    end

    // Read data shows the bank output on the return cycle and holds it afterwards.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdata_c[p] = rvalid_q[p] ? bank_rdata[rbank_q[p]] : hold_q[p];
        end
    end

    assign rd_rvalid_o = rvalid_q;
    assign rd_rdata_o  = {rdata_c[1], rdata_c[0]};

    // Arbitration state and read return tracking.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q     <= 1'b0;
            stall_q  <= '0;
            rvalid_q <= '0;
            rbank_q  <= '0;
            hold_q   <= '0;
        end else begin
            rr_q     <= rr_d;
            stall_q  <= stall_d;
            rvalid_q <= rd_gnt;
            rbank_q  <= rd_bank;
            hold_q   <= rdata_c;
        end
    end

endmodule
